// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Constants and types shared between the SA systolic array and
//               its feeders. Holds the default array geometry, the skewer FSM
//               state type and the width of one lane slice of a weight bus.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

  // Default array geometry. The SA array uses the same values.
  localparam int SA_PE_SIZE    = 4;
  localparam int SA_DATA_WIDTH = 8;
  localparam int SA_PSUM_WIDTH = 32;
  localparam int SA_MAX_K      = 256;

  // Width of one lane slice of a packed weight bus (lane j = [j*W +: W]).
  localparam int SA_LANE_SLICE_W = SA_DATA_WIDTH;

  // Skewer control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } sa_state_e;

endpackage : sa_pkg
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : DEPTH-stage shift register carrying a {data, en} slot per
//               stage, with synchronous clear. The last stage is the output
//               register.
// Ports       : clk, rst      - clock, synchronous active-high clear
//               din_i, en_i   - stage-0 input slot
//               dout_o, en_o  - slot leaving the final stage
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             en_o
);

  // Each stage packs {data, en}; en sits in bit 0.
  logic [WIDTH:0] stage_q [DEPTH];
  logic [WIDTH:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = {din_i, en_i};
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1][WIDTH:1];
  assign en_o   = stage_q[DEPTH-1][0];

endmodule : skew_delay_line
`default_nettype wire

// File: rtl/sa_weight_skewer.sv
`default_nettype none
// ============================================================================
// Module      : sa_weight_skewer
// Description : Accepts a tile of aligned weight vectors on a valid/ready
//               stream and emits them diagonally skewed for the SA array.
//               Lane PE_SIZE-1 leads; lane 0 trails by PE_SIZE-1 cycles.
// Ports       : clk, rst                      - clock, sync active-high reset
//               start_i                       - begin tile (IDLE only)
//               wvec_i/_valid_i/_last_i/_ready_o - weight vector stream
//               weight_col_o, weight_en_col_o - skewed weights and enables
//               psum_en_row_o, psum_row_o     - psum enable (= weight enable),
//                                               psum seed (zero)
//               busy_o, done_o, vec_cnt_o     - status
// Revision    : 1.0 - initial release
// ============================================================================
module sa_weight_skewer
  import sa_pkg::*;
#(
  parameter int PE_SIZE    = SA_PE_SIZE,
  parameter int DATA_WIDTH = SA_LANE_SLICE_W,
  parameter int PSUM_WIDTH = SA_PSUM_WIDTH,
  parameter int MAX_K      = SA_MAX_K
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0]  wvec_i,
  input  logic                           wvec_valid_i,
  input  logic                           wvec_last_i,
  output logic                           wvec_ready_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0]  weight_col_o,
  output logic [PE_SIZE-1:0]             weight_en_col_o,
  output logic [PE_SIZE-1:0]             psum_en_row_o,
  output logic [PSUM_WIDTH*PE_SIZE-1:0]  psum_row_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(MAX_K+1)-1:0]     vec_cnt_o
);

  localparam int CNT_W = $clog2(MAX_K+1);
  localparam int DRN_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [CNT_W-1:0] C_MAX_K    = CNT_W'(MAX_K);
  localparam logic [DRN_W-1:0] C_DRN_LAST = DRN_W'(PE_SIZE-1);

  sa_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             done_q, done_d;
  logic             accept;

  assign accept = (state_q == STREAM) && wvec_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Reaching MAX_K forces the tile closed, so the counter can never
          // pass MAX_K: saturation falls out of leaving STREAM.
          if (wvec_last_i || (cnt_q + CNT_W'(1)) == C_MAX_K) begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
      end
      DRAIN: begin
        // PE_SIZE cycles lets lane 0 (the deepest line) emit its last slot.
        if (drn_q == C_DRN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
    end
  end

  // Lane j delay line is PE_SIZE-j deep, so the top lane appears first.
  for (genvar j = 0; j < PE_SIZE; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_din;
    assign lane_din = accept ? wvec_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_delay_line #(
      .DEPTH (PE_SIZE - j),
      .WIDTH (DATA_WIDTH)
    ) u_dl (
      .clk    (clk),
      .rst    (rst),
      .din_i  (lane_din),
      .en_i   (accept),
      .dout_o (weight_col_o[j*DATA_WIDTH +: DATA_WIDTH]),
      .en_o   (weight_en_col_o[j])
    );
  end : g_lane

  assign wvec_ready_o  = (state_q == STREAM);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign vec_cnt_o     = cnt_q;
  assign psum_en_row_o = weight_en_col_o;
  assign psum_row_o    = '0;

endmodule : sa_weight_skewer
`default_nettype wire

// File: tb/tb_sa_weight_skewer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_weight_skewer
// Description : Bench for sa_weight_skewer. Two instances share the stimulus:
//               MAX_K=256 and MAX_K=3. A tile-level reference model tracks
//               each one and every output is compared after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_weight_skewer;

  localparam int PE = 4;
  localparam int DW = 8;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PE*DW-1:0]  wvec;
  logic              valid;
  logic              last;

  logic              ready0, busy0, done0;
  logic [PE*DW-1:0]  col0;
  logic [PE-1:0]     en0, pen0;
  logic [PE*PW-1:0]  prow0;
  logic [8:0]        cnt0;

  logic              ready1, busy1, done1;
  logic [PE*DW-1:0]  col1;
  logic [PE-1:0]     en1, pen1;
  logic [PE*PW-1:0]  prow1;
  logic [1:0]        cnt1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sa_weight_skewer #(.PE_SIZE(PE), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MAX_K(256)) dut (
    .clk(clk), .rst(rst), .start_i(start), .wvec_i(wvec), .wvec_valid_i(valid),
    .wvec_last_i(last), .wvec_ready_o(ready0), .weight_col_o(col0),
    .weight_en_col_o(en0), .psum_en_row_o(pen0), .psum_row_o(prow0),
    .busy_o(busy0), .done_o(done0), .vec_cnt_o(cnt0)
  );

  sa_weight_skewer #(.PE_SIZE(PE), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MAX_K(3)) dut_k3 (
    .clk(clk), .rst(rst), .start_i(start), .wvec_i(wvec), .wvec_valid_i(valid),
    .wvec_last_i(last), .wvec_ready_o(ready1), .weight_col_o(col1),
    .weight_en_col_o(en1), .psum_en_row_o(pen1), .psum_row_o(prow1),
    .busy_o(busy1), .done_o(done1), .vec_cnt_o(cnt1)
  );

  // ---------------- reference model (one slot per instance) ----------------
  int            maxk    [2] = '{256, 3};
  bit            m_str   [2];   // tile open, vectors being taken
  int            m_drain [2];   // cycles of drain remaining
  int            m_cnt   [2];
  bit            m_done  [2];
  // acc_*[m][k]: what was accepted k edges ago (k=0 is the latest edge).
  bit            acc_e   [2][PE];
  bit [PE*DW-1:0] acc_d  [2][PE];

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit acc;
      acc = m_str[m] && valid;
      for (int k = PE-1; k > 0; k--) begin
        acc_e[m][k] = acc_e[m][k-1];
        acc_d[m][k] = acc_d[m][k-1];
      end
      acc_e[m][0] = acc && !rst;
      acc_d[m][0] = (acc && !rst) ? wvec : '0;
      m_done[m]   = 1'b0;
      if (rst) begin
        m_str[m] = 0; m_drain[m] = 0; m_cnt[m] = 0;
        for (int k = 0; k < PE; k++) begin acc_e[m][k] = 0; acc_d[m][k] = '0; end
      end else if (m_str[m]) begin
        if (acc) begin
          m_cnt[m]++;
          if (last || m_cnt[m] == maxk[m]) begin m_str[m] = 0; m_drain[m] = PE; end
        end
      end else if (m_drain[m] > 0) begin
        if (m_drain[m] == 1) m_done[m] = 1'b1;
        m_drain[m]--;
      end else if (start) begin
        m_str[m] = 1; m_cnt[m] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(int m, logic rdy, logic bsy, logic dn, int cnt,
                          logic [PE-1:0] en, logic [PE-1:0] pen,
                          logic [PE*DW-1:0] col, logic [PE*PW-1:0] prow);
    logic [PE-1:0]    e_en;
    logic [PE*DW-1:0] e_col;
    for (int j = 0; j < PE; j++) begin
      e_en[j]            = acc_e[m][PE-1-j];
      e_col[j*DW +: DW]  = acc_d[m][PE-1-j][j*DW +: DW];
    end
    chk($sformatf("m%0d_ready", m), rdy, m_str[m]);
    chk($sformatf("m%0d_busy", m),  bsy, m_str[m] || (m_drain[m] > 0));
    chk($sformatf("m%0d_done", m),  dn,  m_done[m]);
    chk($sformatf("m%0d_cnt", m),   cnt, m_cnt[m]);
    chk($sformatf("m%0d_en", m),    en,  e_en);
    chk($sformatf("m%0d_psum_en", m), pen, e_en);
    chk($sformatf("m%0d_col", m),   col, e_col);
    chk($sformatf("m%0d_psum_row", m), prow, '0);
  endtask

  task automatic step(bit s, bit v, bit l, logic [PE*DW-1:0] d, bit r);
    rst = r; start = s; valid = v; last = l; wvec = d;
    @(posedge clk);
    model_edge();
    #1;
    chk_inst(0, ready0, busy0, done0, int'(cnt0), en0, pen0, col0, prow0);
    chk_inst(1, ready1, busy1, done1, int'(cnt1), en1, pen1, col1, prow1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  logic [PE-1:0] cap [$];
  logic [PE-1:0] en_tbl [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                4'b0111, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_str[m] = 0; m_drain[m] = 0; m_cnt[m] = 0; m_done[m] = 0;
      for (int k = 0; k < PE; k++) begin acc_e[m][k] = 0; acc_d[m][k] = '0; end
    end

    // Reset with valid high: everything zero, no ready.
    step(0, 1, 0, 32'hdead_beef, 1);
    step(0, 1, 0, 32'hdead_beef, 1);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_col", col0, '0);
    idle(1);

    // Start with valid in the same IDLE cycle: nothing accepted.
    step(1, 1, 0, 32'h0102_0304, 0);
    chk("start_noacc_cnt", cnt0, 0);

    // Four back-to-back vectors, last on the 4th.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i == 3, 32'h0102_0304, 0);
      cap.push_back(en0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, '0, 0);
      cap.push_back(en0);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_en%0d", i), cap[i], en_tbl[i]);
    chk("b2b_done", done0, 1'b1);
    chk("b2b_cnt", cnt0, 4);
    chk("k3_forced_cnt", cnt1, 3);
    idle(2);

    // Bubble between two vectors.
    step(1, 0, 0, '0, 0);
    step(0, 1, 0, 32'haabb_ccdd, 0);
    step(0, 0, 0, 32'h1111_1111, 0);
    step(0, 1, 1, 32'h1122_3344, 0);
    idle(7);
    chk("bubble_cnt", cnt0, 2);

    // Forced last on the MAX_K=3 instance with five valid vectors.
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, $urandom, 0);
    chk("forced_cnt", cnt1, 3);
    step(0, 1, 1, $urandom, 0);
    idle(7);

    // Mid-tile reset after two accepts, then a clean tile.
    step(1, 0, 0, '0, 0);
    step(0, 1, 0, $urandom, 0);
    step(0, 1, 0, $urandom, 0);
    step(0, 1, 0, $urandom, 1);
    chk("midrst_en", en0, '0);
    chk("midrst_busy", busy0, 1'b0);
    idle(6);
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, i == 2, $urandom, 0);
    idle(7);

    // Start ignored in STREAM/DRAIN; start in the done cycle restarts.
    step(1, 0, 0, '0, 0);
    step(1, 1, 0, $urandom, 0);
    step(1, 1, 1, $urandom, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0, 0);
    chk("restart_done", done0, 1'b1);
    step(1, 0, 0, '0, 0);
    chk("restart_ready", ready0, 1'b1);
    step(0, 1, 1, $urandom, 0);
    idle(7);

    // Randomised tiles with bubbles, stray starts and occasional resets.
    for (int t = 0; t < 25; t++) begin
      int len;
      idle($urandom_range(0, 2));
      step(1, $urandom_range(0, 1), 0, $urandom, 0);
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 2) == 0) step($urandom_range(0, 1), 0, 0, $urandom, 0);
        step($urandom_range(0, 1), 1, i == len-1, $urandom, ($urandom_range(0, 19) == 0));
      end
      for (int i = 0; i < PE+2; i++) step(($urandom_range(0, 3) == 0), 0, 0, '0, 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sa_weight_skewer
`default_nettype wire
